// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with operand/result handshakes and bit-serial shifter
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       fs,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             c,
    output logic             v,
    output logic             n,
    output logic             z
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_SHL = 3'b010;
    localparam logic [2:0] OP_SHR = 3'b011;
    localparam logic [2:0] OP_SAR = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [SHW-1:0]   cnt;
    logic [2:0]       sh_op;

    // Decode of the incoming operation
    logic             accept;
    logic             is_shift;
    logic [SHW-1:0]   amt;
    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   cin_ext;
    logic [WIDTH:0]   sum;

    // Single-cycle result for everything that does not need the shifter
    logic [WIDTH-1:0] acc_y;
    logic             acc_c;
    logic             acc_v;

    // One-bit shift step applied to the held y while in SHIFT
    logic [WIDTH-1:0] sh_y;
    logic             sh_c;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    assign is_shift  = (fs == OP_SHL) || (fs == OP_SHR) || (fs == OP_SAR);
    assign amt       = b[SHW-1:0];
    assign is_sub    = (fs == OP_SUB);
    assign b_eff     = is_sub ? ~b : b;
    assign cin_ext   = {{WIDTH{1'b0}}, is_sub};
    assign sum       = {1'b0, a} + {1'b0, b_eff} + cin_ext;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: shifts with a non-zero amount detour through SHIFT
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (is_shift && (amt != '0)) begin
                        state_nx = SHIFT;
                    end else begin
                        state_nx = DONE;
                    end
                end
            end
            SHIFT: begin
                if (cnt == SHW'(1)) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Latency-1 result and flags; a zero-amount shift passes a through with c=0
    always_comb begin
        acc_y = a;
        acc_c = 1'b0;
        acc_v = 1'b0;
        case (fs)
            OP_ADD, OP_SUB: begin
                acc_y = sum[WIDTH-1:0];
                acc_c = sum[WIDTH];
                acc_v = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  acc_y = a & b;
            OP_OR:   acc_y = a | b;
            OP_XOR:  acc_y = a ^ b;
            default: acc_y = a;
        endcase
    end

    // One bit of shift per clock; SAR keeps the sign bit in place
    always_comb begin
        sh_y = y;
        sh_c = 1'b0;
        case (sh_op)
            OP_SHL: begin
                sh_y = {y[WIDTH-2:0], 1'b0};
                sh_c = y[WIDTH-1];
            end
            OP_SHR: begin
                sh_y = {1'b0, y[WIDTH-1:1]};
                sh_c = y[0];
            end
            OP_SAR: begin
                sh_y = {y[WIDTH-1], y[WIDTH-1:1]};
                sh_c = y[0];
            end
            default: begin
                sh_y = y;
                sh_c = 1'b0;
            end
        endcase
    end

    // Result/flag registers; held untouched in DONE until the consumer takes them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y     <= '0;
            c     <= 1'b0;
            v     <= 1'b0;
            n     <= 1'b0;
            z     <= 1'b0;
            cnt   <= '0;
            sh_op <= OP_ADD;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_shift && (amt != '0)) begin
                            y     <= a;
                            c     <= 1'b0;
                            v     <= 1'b0;
                            cnt   <= amt;
                            sh_op <= fs;
                        end else begin
                            y <= acc_y;
                            c <= acc_c;
                            v <= acc_v;
                            n <= acc_y[WIDTH-1];
                            z <= (acc_y == '0);
                        end
                    end
                end
                SHIFT: begin
                    y   <= sh_y;
                    c   <= sh_c;
                    cnt <= cnt - SHW'(1);
                    if (cnt == SHW'(1)) begin
                        n <= sh_y[WIDTH-1];
                        z <= (sh_y == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized self-checking bench for alu_seq against an arithmetic reference model
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [2:0] fs = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] y;
    logic       c;
    logic       v;
    logic       n;
    logic       z;

    int checks = 0;
    int failures = 0;

    alu_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .fs        (fs),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .c         (c),
        .v         (v),
        .n         (n),
        .z         (z)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic and language shift operators
    function automatic void model(input logic [2:0] f, input logic [7:0] aa, input logic [7:0] bb,
                                  output logic [7:0] ey, output logic ec, output logic ev,
                                  output int lat);
        int k;
        int sa;
        int sb;
        int sr;
        k   = int'(bb[2:0]);
        sa  = $signed(aa);
        sb  = $signed(bb);
        ey  = aa;
        ec  = 1'b0;
        ev  = 1'b0;
        lat = 1;
        case (f)
            3'd0: begin
                ey = aa + bb;
                ec = (int'(aa) + int'(bb)) > 255;
                sr = sa + sb;
                ev = (sr > 127) || (sr < -128);
            end
            3'd1: begin
                ey = aa - bb;
                ec = (aa >= bb);
                sr = sa - sb;
                ev = (sr > 127) || (sr < -128);
            end
            3'd2: begin
                ey  = aa << k;
                ec  = (k != 0) ? aa[8-k] : 1'b0;
                lat = (k != 0) ? k + 1 : 1;
            end
            3'd3: begin
                ey  = aa >> k;
                ec  = (k != 0) ? aa[k-1] : 1'b0;
                lat = (k != 0) ? k + 1 : 1;
            end
            3'd4: begin
                ey  = 8'($signed(aa) >>> k);
                ec  = (k != 0) ? aa[k-1] : 1'b0;
                lat = (k != 0) ? k + 1 : 1;
            end
            3'd5: ey = aa & bb;
            3'd6: ey = aa | bb;
            default: ey = aa ^ bb;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] f, input logic [7:0] aa, input logic [7:0] bb, input int hold);
        logic [7:0] ey;
        logic       ec;
        logic       ev;
        int         lat;
        int         cyc;
        logic       busy_hi;
        model(f, aa, bb, ey, ec, ev, lat);
        @(negedge clk);
        chk("idle_rdy", in_ready, 1);
        fs = f;
        a = aa;
        b = bb;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        busy_hi = 1'b0;
        while (!out_valid && cyc < 40) begin
            if (in_ready) busy_hi = 1'b1;
            in_valid = 1'($urandom);
            a = 8'($urandom);
            b = 8'($urandom);
            fs = 3'($urandom);
            @(negedge clk);
            cyc++;
        end
        chk("latency", cyc, lat);
        chk("busy_rdy", busy_hi, 0);
        chk("done_rdy", in_ready, 0);
        chk("y", y, ey);
        chk("c", c, ec);
        chk("v", v, ev);
        chk("n", n, ey[7]);
        chk("z", z, (ey == 8'h00));
        repeat (hold) begin
            in_valid = 1'($urandom);
            a = 8'($urandom);
            b = 8'($urandom);
            fs = 3'($urandom);
            out_ready = 1'b0;
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_rdy", in_ready, 0);
            chk("hold_ycvnz", {y, c, v, n, z}, {ey, ec, ev, ey[7], (ey == 8'h00)});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("drain_valid", out_valid, 0);
        chk("drain_rdy", in_ready, 1);
    endtask

    initial begin
        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_rdy", in_ready, 1);
        chk("rst_ycvnz", {y, c, v, n, z}, 12'h000);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(3'd0, 8'h7F, 8'h01, 0);
        run_op(3'd1, 8'h05, 8'h05, 0);
        run_op(3'd1, 8'h00, 8'h01, 0);
        run_op(3'd3, 8'h81, 8'h01, 0);
        run_op(3'd4, 8'h80, 8'h07, 0);
        run_op(3'd2, 8'h81, 8'h00, 0);
        run_op(3'd2, 8'h81, 8'h07, 0);
        run_op(3'd3, 8'hFF, 8'hF8, 0);
        run_op(3'd7, 8'hF0, 8'hFF, 0);
        run_op(3'd0, 8'hFF, 8'h01, 0);
        run_op(3'd1, 8'h80, 8'h01, 0);
        run_op(3'd0, 8'h12, 8'h34, 5);

        // Reset in the middle of a long shift must abort it
        @(negedge clk);
        fs = 3'd2;
        a = 8'h01;
        b = 8'h07;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_rdy", in_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", out_valid, 0);
        chk("abort_rdy", in_ready, 1);
        chk("abort_ycvnz", {y, c, v, n, z}, 12'h000);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(3'd0, 8'h02, 8'h03, 0);

        for (int i = 0; i < 150; i++) begin
            run_op(3'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
